// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, bus width and sequencer state encoding for the 9-bit core
package cpu_pkg;
  localparam int DATA_W = 9;
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_MV   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVI  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_I, S_LATCH_I, S_FETCH_M, S_LATCH_M, S_EXEC0, S_EXEC, S_HALTED
  } seq_state_t;
  function automatic logic [2:0] opcode(input logic [DATA_W-1:0] w);
    return w[DATA_W-1 -: 3];
  endfunction
endpackage

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches program words from a synchronous ROM and feeds them to the core until HALT or stop
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] din,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);
  seq_state_t state, state_n;
  logic [ADDR_W-1:0] pc_n, addr_n, pc_step;
  logic [DATA_W-1:0] din_n, ir_buf, ir_n, imm_buf, imm_n;
  logic run_n, is_mvi;
  assign is_mvi  = opcode(ir_buf) == OP_MVI;
  assign pc_step = pc + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));
  assign busy    = !(state == S_IDLE || state == S_HALTED);
  assign halted  = state == S_HALTED;
  always_comb begin
    state_n = state;
    pc_n    = pc;
    addr_n  = mem_addr;
    din_n   = din;
    run_n   = run;
    ir_n    = ir_buf;
    imm_n   = imm_buf;
    case (state)
      S_IDLE, S_HALTED: begin
        if (start && !stop) begin
          state_n = S_FETCH_I;
          addr_n  = pc;
        end
      end
      S_FETCH_I: state_n = S_LATCH_I;
      S_LATCH_I: begin
        ir_n = mem_rdata;
        if (opcode(mem_rdata) == OP_HALT) state_n = S_HALTED;
        else if (opcode(mem_rdata) == OP_MVI) begin
          state_n = S_FETCH_M;
          addr_n  = pc + ADDR_W'(1);
        end else begin
          state_n = S_EXEC0;
          run_n   = 1'b1;
          din_n   = mem_rdata;
        end
      end
      S_FETCH_M: state_n = S_LATCH_M;
      S_LATCH_M: begin
        imm_n   = mem_rdata;
        state_n = S_EXEC0;
        run_n   = 1'b1;
        din_n   = ir_buf;
      end
      S_EXEC0: begin
        state_n = S_EXEC;
        din_n   = is_mvi ? imm_buf : ir_buf;
      end
      S_EXEC: begin
        if (done) begin
          run_n   = 1'b0;
          pc_n    = pc_step;
          state_n = stop ? S_HALTED : S_FETCH_I;
          addr_n  = stop ? mem_addr : pc_step;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      mem_addr <= '0;
      din      <= '0;
      run      <= 1'b0;
      ir_buf   <= '0;
      imm_buf  <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      mem_addr <= addr_n;
      din      <= din_n;
      run      <= run_n;
      ir_buf   <= ir_n;
      imm_buf  <= imm_n;
    end
  end
endmodule
